// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM audio transmitter and receiver.
// Holds the sequencing state type and the default frame geometry.
package tdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } tdm_state_e;

    localparam int TDM_SLOTS               = 2;
    localparam int TDM_SAMPLE_WIDTH        = 24;
    localparam int TDM_SLOT_WIDTH          = 32;
    localparam int TDM_CYCLES_PER_HALF_SCK = 25;

endpackage

// File: rtl/sck_gen.sv
// SCK divider: free-runs while enabled, parks low when disabled.
// rise/fall strobes are high in the clk_in cycle whose closing edge moves sck_out.
module sck_gen
    import tdm_pkg::*;
#(
    parameter int CYCLES_PER_HALF_SCK = TDM_CYCLES_PER_HALF_SCK
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic run_in,
    output logic sck_out,
    output logic rise_out,
    output logic fall_out
);

    localparam int CW = (CYCLES_PER_HALF_SCK > 1) ? $clog2(CYCLES_PER_HALF_SCK) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_HALF_SCK - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          wrap;

    always_comb begin
        cnt_d = '0;
        sck_d = 1'b0;
        wrap  = 1'b0;
        if (run_in) begin
            wrap  = (cnt_q == CNT_LAST);
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            sck_d = wrap ? ~sck_q : sck_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_out  = sck_q;
    assign rise_out = wrap & ~sck_q;
    assign fall_out = wrap & sck_q;

endmodule

// File: rtl/tdm_transmit.sv
// TDM audio serializer: one-deep holding buffer feeding a framed SCK/WS/SD stream.
// state   | meaning
// IDLE    | sck parked low, waiting for enable_in
// SYNC    | one SCK period of ws=1 ahead of the first frame
// RUN     | shifting frame bits; ws marks the last bit when another frame follows
module tdm_transmit
    import tdm_pkg::*;
#(
    parameter int SLOTS               = TDM_SLOTS,
    parameter int SAMPLE_WIDTH        = TDM_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH          = TDM_SLOT_WIDTH,
    parameter int CYCLES_PER_HALF_SCK = TDM_CYCLES_PER_HALF_SCK
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           enable_in,
    input  logic signed [SAMPLE_WIDTH-1:0] audio_in [SLOTS],
    input  logic                           valid_in,
    output logic                           ready_out,
    output logic                           sck_out,
    output logic                           ws_out,
    output logic                           sd_out,
    output logic                           frame_start_out,
    output logic                           underrun_out
);

    localparam int FRAME_BITS = SLOTS * SLOT_WIDTH;
    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    tdm_state_e            state_q, state_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [FRAME_BITS-1:0] buf_q, buf_d;
    logic                  full_q, full_d;
    logic                  sd_q, sd_d;
    logic                  ws_q, ws_d;
    logic                  fs_q, fs_d;
    logic                  ur_q, ur_d;
    logic [FRAME_BITS-1:0] audio_packed;
    logic                  launch;
    logic                  capture;
    logic                  sck_rise;
    logic                  sck_fall;

    sck_gen #(
        .CYCLES_PER_HALF_SCK(CYCLES_PER_HALF_SCK)
    ) u_sck_gen (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .run_in  (state_q != ST_IDLE),
        .sck_out (sck_out),
        .rise_out(sck_rise),
        .fall_out(sck_fall)
    );

    // Frame bit 0 sits at the MSB; padding bits stay zero.
    always_comb begin
        audio_packed = '0;
        for (int s = 0; s < SLOTS; s++) begin
            audio_packed[FRAME_BITS-1-s*SLOT_WIDTH -: SAMPLE_WIDTH] = audio_in[s];
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        buf_d   = buf_q;
        full_d  = full_q;
        sd_d    = sd_q;
        ws_d    = ws_q;
        fs_d    = 1'b0;
        ur_d    = 1'b0;
        launch  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable_in) begin
                    state_d = ST_SYNC;
                    ws_d    = 1'b1;
                    sd_d    = 1'b0;
                end
            end
            ST_SYNC: begin
                launch = sck_fall;
            end
            ST_RUN: begin
                if (sck_fall) begin
                    if (bit_q == BIT_LAST) begin
                        // ws on the last bit already recorded whether to continue
                        if (ws_q) begin
                            launch = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            bit_d   = '0;
                            sd_d    = 1'b0;
                            ws_d    = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sd_d  = frame_q[BIT_LAST - bit_d];
                        ws_d  = (bit_d == BIT_LAST) && enable_in;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch) begin
            state_d = ST_RUN;
            bit_d   = '0;
            ws_d    = 1'b0;
            fs_d    = 1'b1;
            if (full_q) begin
                frame_d = buf_q;
                full_d  = 1'b0;
            end else begin
                ur_d = 1'b1;
            end
            sd_d = frame_d[FRAME_BITS-1];
        end

        // A load in this cycle frees the buffer, so a simultaneous capture refills it.
        capture = valid_in && (!full_q || launch);
        if (capture) begin
            buf_d  = audio_packed;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            frame_q <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            sd_q    <= 1'b0;
            ws_q    <= 1'b0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            sd_q    <= sd_d;
            ws_q    <= ws_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
        end
    end

    assign ready_out       = ~full_q;
    assign ws_out          = ws_q;
    assign sd_out          = sd_q;
    assign frame_start_out = fs_q;
    assign underrun_out    = ur_q;

endmodule

// File: doc/tdm_transmit.md
TDM_TRANSMIT -- requirements
Module: tdm_transmit

Interface
REQ-001 SHALL have parameter SLOTS, default 2, number of TDM slots per frame.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 24, audio bits per slot, sent MSB first.
REQ-003 SHALL have parameter SLOT_WIDTH, default 32, SCK periods per slot; bits after the sample are zero padding.
REQ-004 SHALL have parameter CYCLES_PER_HALF_SCK, default 25, clk_in cycles per SCK half-period (2 MHz SCK at 100 MHz).
REQ-005 SHALL have port clk_in, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable_in, input, 1, level; high runs frames, low stops after the current frame.
REQ-008 SHALL have port audio_in, input, SLOTS x SAMPLE_WIDTH unpacked array, signed samples; index 0 goes in slot 0.
REQ-009 SHALL have port valid_in, input, 1, audio_in valid.
REQ-010 SHALL have port ready_out, output, 1, holding buffer empty.
REQ-011 SHALL have port sck_out, output, 1, TDM bit clock.
REQ-012 SHALL have port ws_out, output, 1, frame sync.
REQ-013 SHALL have port sd_out, output, 1, serial data.
REQ-014 SHALL have port frame_start_out, output, 1, one-cycle pulse when bit 0 of a frame is launched.
REQ-015 SHALL have port underrun_out, output, 1, one-cycle pulse when a frame starts with no new sample.

Function
REQ-016 SHALL define FRAME_BITS = SLOTS*SLOT_WIDTH (64 at defaults).
REQ-017 SHALL run a half-period counter 0..CYCLES_PER_HALF_SCK-1 whenever state is not IDLE; sck_out toggles on wrap.
REQ-018 SHALL drive sck_out low in IDLE; the first toggle after leaving IDLE SHALL be rising.
REQ-019 SHALL change sd_out and ws_out only in the clk_in cycle where sck_out falls, so they are stable at every SCK rising edge.
REQ-020 SHALL implement states IDLE, SYNC and RUN.
REQ-021 IDLE -> SYNC: the cycle enable_in is sampled high.
REQ-022 SYNC SHALL last one SCK period with ws_out=1 and sd_out=0; SYNC -> RUN on the falling edge that launches bit 0.
REQ-023 RUN SHALL shift out bit index 0..FRAME_BITS-1, one per SCK period; slot s, bit b (b<SAMPLE_WIDTH) = sample[s][SAMPLE_WIDTH-1-b], else 0.
REQ-024 On bit FRAME_BITS-1: if enable_in is high, ws_out=1 for that period and bit 0 of the next frame follows with no gap; if low, ws_out=0 and the state goes to IDLE at the next falling edge.
REQ-025 ws_out SHALL be 0 in all other periods, so it is exactly one SCK period high before every frame.
REQ-026 At each bit-0 launch, a full holding buffer SHALL load the shift registers and empty; otherwise the previous frame's samples SHALL repeat and underrun_out SHALL pulse.
REQ-027 frame_start_out SHALL pulse in the same cycle as every bit-0 launch.
REQ-028 ready_out SHALL equal "holding buffer empty"; valid_in && ready_out captures audio_in; valid_in while not ready SHALL be ignored.
REQ-029 When capture and bit-0 load happen in the same cycle, the load SHALL take the old buffer content and the capture SHALL refill it; ready_out stays 0.
REQ-030 Dropping enable_in mid-frame SHALL NOT truncate the frame.

Reset
REQ-031 With rst_in low, all outputs SHALL be 0 except ready_out, which SHALL be 1.
REQ-032 With rst_in low, state SHALL be IDLE, all counters SHALL be 0, and shift and holding registers SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL abort immediately with no partial completion.

Structure
REQ-034 The state enum and the default parameter constants SHALL live in a shared package, tdm_pkg, alongside the receiver.
REQ-035 The SCK divider SHALL be one sub-module, sck_gen, providing sck_out plus one-cycle rise and fall strobes.

Verification
REQ-036 Reset, then enable_in=1 with audio {24'h800001, 24'h7FFFFF} loaded before SYNC: a loopback tdm_receive SHALL return the same two samples; the first bit of sd_out SHALL be 1.
REQ-037 Hold enable_in high with no further valid_in: frame 2 SHALL repeat frame 1; underrun_out SHALL pulse once per frame; frame_start_out SHALL be spaced 64*50=3200 cycles.
REQ-038 Drop enable_in at bit 10: all 64 bits SHALL complete, ws_out SHALL stay 0 on bit 63, then sck_out SHALL be held low.
REQ-039 Assert valid_in in the exact bit-0 launch cycle: the old sample SHALL go out, the new one SHALL go out next frame, and there SHALL be no underrun.
REQ-040 Pull rst_in low at bit 40 for 3 cycles: outputs SHALL be 0 and ready_out 1 within the same cycle; after release, SYNC SHALL restart.
REQ-041 Check ws_out and sd_out at every sck_out rising edge: neither SHALL change within ±1 cycle of that edge.
